// File: rtl/rc4_pkg.sv
// Shared state encoding, message character set and helpers for the RC4 key search.
package rc4_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    RUN       = 3'd2,
    NEXT      = 3'd3,
    FOUND     = 3'd4,
    EXHAUSTED = 3'd5
  } state_e;

  localparam logic [7:0] CHAR_LO     = 8'h61;
  localparam logic [7:0] CHAR_HI     = 8'h7A;
  localparam logic [7:0] CHAR_SPACE  = 8'h20;
  localparam int         MSG_LEN_DEF = 32;

  // Plaintext is accepted only if every byte is lowercase a-z or space.
  function automatic logic is_valid_char(input logic [7:0] b);
    return ((b >= CHAR_LO) && (b <= CHAR_HI)) || (b == CHAR_SPACE);
  endfunction

endpackage

// File: rtl/key_search_ctrl_msg_byte_checker.sv
// Counts decrypted bytes (saturating at MSG_LEN) and remembers whether any was outside the plaintext set.
module msg_byte_checker
  import rc4_pkg::*;
#(
  parameter int MSG_LEN = MSG_LEN_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       valid,
  input  logic [7:0] data,
  output logic       bad,
  output logic       complete,
  output logic       bad_now
);

  localparam int CNT_W = $clog2(MSG_LEN + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(MSG_LEN);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bad_q;

  // complete reflects the count including a byte arriving this cycle.
  always_comb begin
    bad_now = valid && !is_valid_char(data);
    cnt_d   = cnt_q;
    if (valid && (cnt_q != FULL)) cnt_d = cnt_q + 1'b1;
    complete = (cnt_d == FULL);
    bad      = bad_q;
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt_q <= '0;
      bad_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      bad_q <= bad_q | bad_now;
    end
  end

endmodule

// File: rtl/key_search_ctrl.sv
// Brute-force RC4 key scheduler: issues candidate keys, restarts the sequencer, judges decrypted text.
// Optional: define EARLY_ABORT_EN to abandon a key on its first bad byte instead of waiting for rc4_done.
module key_search_ctrl
  import rc4_pkg::*;
#(
  parameter int KEY_WIDTH      = 24,
  parameter int KEY_SPACE_BITS = 22,
  parameter int MSG_LEN        = MSG_LEN_DEF,
  parameter int KEY_START      = 0,
  parameter int KEY_STEP       = 1
) (
  input  logic                    CLOCK_50,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    stop,
  output logic [KEY_WIDTH-1:0]    key,
  output logic                    key_load,
  output logic                    key_valid,
  input  logic                    rc4_done,
  input  logic                    dec_byte_valid,
  input  logic [7:0]              dec_byte,
  output logic                    busy,
  output logic                    found,
  output logic                    exhausted,
  output logic [KEY_WIDTH-1:0]    found_key,
  output logic [KEY_SPACE_BITS:0] keys_tried,
  output logic [2:0]              state
);

  localparam logic [KEY_SPACE_BITS-1:0] START_K = KEY_SPACE_BITS'(KEY_START);
  localparam logic [KEY_SPACE_BITS:0]   STEP_K  = (KEY_SPACE_BITS + 1)'(KEY_STEP);
  localparam logic [KEY_SPACE_BITS:0]   KEY_MAX = {1'b0, {KEY_SPACE_BITS{1'b1}}};

  state_e                    state_q;
  logic [KEY_SPACE_BITS-1:0] key_q, fkey_q;
  logic [KEY_SPACE_BITS:0]   tried_q;
  logic                      key_load_q, key_valid_q, busy_q, found_q, exh_q;

  logic                      byte_v, chk_clear, bad_flag, bad_now, complete, pass, abort_now;
  logic [KEY_SPACE_BITS:0]   key_sum;

  assign byte_v    = dec_byte_valid && (state_q == RUN);
  assign chk_clear = (state_q == LOAD);
  // Extra bit keeps the stepped key from wrapping back into the searched range.
  assign key_sum   = {1'b0, key_q} + STEP_K;
  assign pass      = !(bad_flag || bad_now) && complete;

`ifdef EARLY_ABORT_EN
  assign abort_now = bad_now;
`else
  assign abort_now = 1'b0;
`endif

  msg_byte_checker #(.MSG_LEN(MSG_LEN)) u_chk (
    .clk      (CLOCK_50),
    .rst      (reset),
    .clear    (chk_clear),
    .valid    (byte_v),
    .data     (dec_byte),
    .bad      (bad_flag),
    .complete (complete),
    .bad_now  (bad_now)
  );

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q     <= IDLE;
      key_q       <= '0;
      fkey_q      <= '0;
      tried_q     <= '0;
      key_load_q  <= 1'b0;
      key_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      found_q     <= 1'b0;
      exh_q       <= 1'b0;
    end else begin
      key_load_q <= 1'b0;
      if (stop && (state_q != IDLE)) begin
        state_q     <= IDLE;
        key_valid_q <= 1'b0;
        busy_q      <= 1'b0;
      end else begin
        case (state_q)
          IDLE, FOUND, EXHAUSTED: begin
            if (start) begin
              state_q     <= LOAD;
              key_q       <= START_K;
              fkey_q      <= '0;
              tried_q     <= '0;
              found_q     <= 1'b0;
              exh_q       <= 1'b0;
              key_load_q  <= 1'b1;
              key_valid_q <= 1'b0;
              busy_q      <= 1'b1;
            end
          end
          LOAD: begin
            state_q     <= RUN;
            key_valid_q <= 1'b1;
          end
          RUN: begin
            if (rc4_done && pass) begin
              state_q <= FOUND;
              fkey_q  <= key_q;
              found_q <= 1'b1;
              tried_q <= tried_q + 1'b1;
              busy_q  <= 1'b0;
            end else if (rc4_done || abort_now) begin
              state_q     <= NEXT;
              key_valid_q <= 1'b0;
            end
          end
          NEXT: begin
            tried_q <= tried_q + 1'b1;
            if (key_sum > KEY_MAX) begin
              state_q <= EXHAUSTED;
              exh_q   <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              state_q    <= LOAD;
              key_q      <= key_sum[KEY_SPACE_BITS-1:0];
              key_load_q <= 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign key        = KEY_WIDTH'(key_q);
  assign found_key  = KEY_WIDTH'(fkey_q);
  assign keys_tried = tried_q;
  assign key_load   = key_load_q;
  assign key_valid  = key_valid_q;
  assign busy       = busy_q;
  assign found      = found_q;
  assign exhausted  = exh_q;
  assign state      = state_q;

endmodule
